// File: rtl/modulation_scheduler.sv
// Run sequencer for the az / no-az modulation blocks: arms on trigger, holds the modulator in reset,
// counts ADC conversions up to a programmed total and aborts on a stalled ADC.
module modulation_scheduler #(
  parameter int unsigned CLK_FREQ       = 20000000,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cfg_mode,
  input  logic [3:0]       cfg_azmux_lo_val,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             arm,
  input  logic             trig,
  input  logic             adc_measure_valid,
  output logic             mod_reset,
  output logic [1:0]       mod_sel,
  output logic [3:0]       azmux_lo_val,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sample_count
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  if (CLK_FREQ == 0 || RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("modulation_scheduler: CLK_FREQ, RST_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    RESET_MOD = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state_r;
  logic             trig_r;
  logic             valid_r;
  logic [CNT_W-1:0] target_r;
  logic [RST_W-1:0] rst_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  logic             trig_rise_s;
  logic             valid_rise_s;
  logic             mode_ok_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             final_s;

  // Edge detection and next-count arithmetic shared by the FSM.
  always_comb begin
    trig_rise_s  = trig & ~trig_r;
    valid_rise_s = adc_measure_valid & ~valid_r;
    mode_ok_s    = (cfg_mode == 2'd1) || (cfg_mode == 2'd2);
    count_inc_s  = sample_count + CNT_W'(1);
    final_s      = (target_r != {CNT_W{1'b0}}) && (count_inc_s == target_r);
  end

  // Run FSM; every output is registered and updated on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      trig_r       <= 1'b0;
      valid_r      <= 1'b0;
      target_r     <= {CNT_W{1'b0}};
      rst_cnt_r    <= {RST_W{1'b0}};
      tmo_cnt_r    <= {TMO_W{1'b0}};
      mod_reset    <= 1'b1;
      mod_sel      <= 2'd0;
      azmux_lo_val <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      sample_count <= {CNT_W{1'b0}};
    end else begin
      trig_r  <= trig;
      valid_r <= adc_measure_valid;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          mod_reset <= 1'b1;
          busy      <= 1'b0;
          if (arm && mode_ok_s) begin
            state_r <= ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          if (!arm) begin
            state_r <= IDLE;
          end else if (trig_rise_s) begin
            mod_sel      <= cfg_mode;
            azmux_lo_val <= cfg_azmux_lo_val;
            target_r     <= cfg_count;
            sample_count <= {CNT_W{1'b0}};
            timeout_err  <= 1'b0;
            rst_cnt_r    <= RST_W'(RST_CYCLES - 1);
            busy         <= 1'b1;
            state_r      <= RESET_MOD;
          end else begin
            state_r <= ARMED;
          end
        end
        RESET_MOD: begin
          if (rst_cnt_r == {RST_W{1'b0}}) begin
            mod_reset <= 1'b0;
            tmo_cnt_r <= TMO_W'(TIMEOUT_CYCLES - 1);
            state_r   <= RUN;
          end else begin
            rst_cnt_r <= rst_cnt_r - RST_W'(1);
          end
        end
        RUN: begin
          // A conversion is counted even when an abort lands on the same cycle.
          if (valid_rise_s) begin
            sample_count <= count_inc_s;
          end else begin
            sample_count <= sample_count;
          end
          if (!arm) begin
            mod_reset <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else if (valid_rise_s) begin
            tmo_cnt_r <= TMO_W'(TIMEOUT_CYCLES - 1);
            if (final_s) begin
              mod_reset <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r <= RUN;
            end
          end else if (tmo_cnt_r == {TMO_W{1'b0}}) begin
            timeout_err <= 1'b1;
            mod_reset   <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r - TMO_W'(1);
          end
        end
        DONE: begin
          if (arm) begin
            state_r <= ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          mod_reset <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulation_scheduler.sv
// Directed bench for modulation_scheduler with a short timeout and a narrow counter to reach wrap.
module tb_modulation_scheduler;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       cfg_mode = 2'd0;
  logic [3:0]       cfg_azmux_lo_val = 4'd0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             arm = 1'b0;
  logic             trig = 1'b0;
  logic             adc_measure_valid = 1'b0;
  logic             mod_reset;
  logic [1:0]       mod_sel;
  logic [3:0]       azmux_lo_val;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] sample_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  modulation_scheduler #(
    .CLK_FREQ(20000000), .RST_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_azmux_lo_val(cfg_azmux_lo_val),
    .cfg_count(cfg_count), .arm(arm), .trig(trig), .adc_measure_valid(adc_measure_valid),
    .mod_reset(mod_reset), .mod_sel(mod_sel), .azmux_lo_val(azmux_lo_val), .busy(busy),
    .done(done), .timeout_err(timeout_err), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse();
    adc_measure_valid = 1'b1;
    cyc(1);
    adc_measure_valid = 1'b0;
    cyc(1);
  endtask

  // Trigger from ARMED and wait out the RST_CYCLES=4 modulator reset window.
  task automatic start_run();
    trig = 1'b1;
    cyc(1);
    trig = 1'b0;
    cyc(4);
  endtask

  initial begin
    cyc(2);
    chk("rst_mod_reset", mod_reset, 1);
    chk("rst_mod_sel", mod_sel, 0);
    chk("rst_lo_val", azmux_lo_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_count", sample_count, 0);
    reset = 1'b0;

    // Normal az run of 4 conversions with a mid-run config change.
    cfg_mode = 2'd1; cfg_count = 4'd4; cfg_azmux_lo_val = 4'hA; arm = 1'b1;
    cyc(1);
    trig = 1'b1;
    cyc(1);
    trig = 1'b0;
    chk("t1_busy_resetmod", busy, 1);
    chk("t1_mod_sel", mod_sel, 1);
    cyc(3);
    chk("t1_modrst_held", mod_reset, 1);
    cyc(1);
    chk("t1_modrst_low", mod_reset, 0);
    cfg_azmux_lo_val = 4'h3;
    cfg_mode = 2'd2;
    for (int i = 1; i <= 3; i++) begin
      pulse();
      chk("t1_count", sample_count, i);
      chk("t1_no_done", done, 0);
    end
    chk("t1_lo_val_kept", azmux_lo_val, 4'hA);
    chk("t1_mod_sel_kept", mod_sel, 1);
    adc_measure_valid = 1'b1;
    cyc(1);
    chk("t1_done", done, 1);
    chk("t1_final_count", sample_count, 4);
    chk("t1_busy_off", busy, 0);
    chk("t1_modrst_high", mod_reset, 1);
    adc_measure_valid = 1'b0;
    cyc(1);
    chk("t1_done_one_cycle", done, 0);

    // Timeout after 2 of 3 conversions.
    cfg_mode = 2'd1; cfg_count = 4'd3;
    start_run();
    chk("t2_count_cleared", sample_count, 0);
    chk("t2_lo_val_new", azmux_lo_val, 4'h3);
    pulse();
    pulse();
    cyc(98);
    chk("t2_still_busy", busy, 1);
    chk("t2_no_timeout_yet", timeout_err, 0);
    cyc(1);
    chk("t2_timeout", timeout_err, 1);
    chk("t2_busy_off", busy, 0);
    chk("t2_modrst", mod_reset, 1);
    chk("t2_no_done", done, 0);
    chk("t2_count", sample_count, 2);

    // Abort after 2 of 5 conversions.
    cyc(1);
    cfg_count = 4'd5;
    start_run();
    chk("t3_timeout_cleared", timeout_err, 0);
    pulse();
    pulse();
    arm = 1'b0;
    cyc(1);
    chk("t3_modrst", mod_reset, 1);
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    chk("t3_count", sample_count, 2);
    pulse();
    chk("t3_count_retained", sample_count, 2);

    // Off and reserved modes never start.
    cfg_mode = 2'd0; arm = 1'b1;
    cyc(1);
    start_run();
    chk("t4_mode0_busy", busy, 0);
    chk("t4_mode0_modrst", mod_reset, 1);
    cfg_mode = 2'd3;
    cyc(1);
    start_run();
    chk("t4_mode3_busy", busy, 0);
    chk("t4_mode3_modrst", mod_reset, 1);

    // Abort and final conversion in the same cycle: abort wins, count still increments.
    cfg_mode = 2'd2; cfg_count = 4'd1;
    cyc(1);
    start_run();
    chk("t5_mod_sel", mod_sel, 2);
    chk("t5_running", mod_reset, 0);
    adc_measure_valid = 1'b1; arm = 1'b0;
    cyc(1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_count", sample_count, 1);
    adc_measure_valid = 1'b0;
    cyc(1);
    chk("t5_done_later", done, 0);

    // Free-running run wraps 15 -> 0 without done; retrigger while busy is ignored.
    cfg_mode = 2'd1; cfg_count = 4'd0; arm = 1'b1;
    cyc(1);
    start_run();
    for (int i = 1; i <= 17; i++) begin
      pulse();
      chk("t6_no_done", done, 0);
    end
    chk("t6_wrap_count", sample_count, 1);
    chk("t6_busy", busy, 1);
    start_run();
    chk("t6_retrig_count", sample_count, 1);
    chk("t6_retrig_busy", busy, 1);

    // Asynchronous reset mid-run at count 2, then a clean recovery run.
    pulse();
    chk("t7_count_before", sample_count, 2);
    reset = 1'b1;
    #1;
    chk("t7_modrst", mod_reset, 1);
    chk("t7_busy", busy, 0);
    chk("t7_count", sample_count, 0);
    chk("t7_mod_sel", mod_sel, 0);
    chk("t7_lo_val", azmux_lo_val, 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    start_run();
    chk("t7_recovery_running", mod_reset, 0);
    pulse();
    chk("t7_recovery_count", sample_count, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
